// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the 2-read/1-write register file.
package regfile_pkg;

    localparam int unsigned RF_DATA_W     = 16;
    localparam int unsigned RF_ADDR_W     = 3;
    // Upper bound on address width supported by the one-hot decoder.
    localparam int unsigned RF_MAX_ADDR_W = 8;
    localparam int unsigned RF_MAX_NREGS  = 1 << RF_MAX_ADDR_W;

    // One-hot write decode; callers keep the low NREGS bits.
    function automatic logic [RF_MAX_NREGS-1:0] rf_onehot(input logic [RF_MAX_ADDR_W-1:0] addr);
        rf_onehot = RF_MAX_NREGS'(1) << addr;
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// One registered read port: NREGS:1 mux, optional write bypass, output register.
module rf_read_port
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = RF_DATA_W,
    parameter int unsigned ADDR_W = RF_ADDR_W,
    parameter int unsigned NREGS  = 2 ** ADDR_W,
    parameter int unsigned BYPASS = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NREGS-1:0][DATA_W-1:0] regs,
    input  logic [ADDR_W-1:0]            readnum,
    input  logic                         write,
    input  logic [ADDR_W-1:0]            writenum,
    input  logic [DATA_W-1:0]            data_in,
    output logic [DATA_W-1:0]            data_out
);

    logic [DATA_W-1:0] rd_c;
    logic              hit_c;
    logic [DATA_W-1:0] next_c;

    // Array read plus same-cycle write forwarding when bypass is enabled.
    always_comb begin
        rd_c   = regs[readnum];
        hit_c  = write && (writenum == readnum);
        next_c = rd_c;
        if ((BYPASS != 0) && hit_c) begin
            next_c = data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out <= '0;
        end else begin
            data_out <= next_c;
        end
    end

endmodule

// File: rtl/regfile_2r1w.sv
// Parametrised register file: one write port, two registered read ports, written bitmap.
module regfile_2r1w
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = RF_DATA_W,
    parameter int unsigned ADDR_W = RF_ADDR_W,
    parameter int unsigned NREGS  = 2 ** ADDR_W,
    parameter int unsigned BYPASS = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ADDR_W-1:0] writenum,
    input  logic              write,
    input  logic [ADDR_W-1:0] readnum_a,
    input  logic [ADDR_W-1:0] readnum_b,
    output logic [DATA_W-1:0] data_out_a,
    output logic [DATA_W-1:0] data_out_b,
    output logic [NREGS-1:0]  written
);

    logic [NREGS-1:0][DATA_W-1:0] regs;
    logic [NREGS-1:0]             wr_onehot_c;

    always_comb begin
        wr_onehot_c = NREGS'(rf_onehot(RF_MAX_ADDR_W'(writenum)));
    end

    // Storage and sticky written flags; reset wins over a coincident write.
    always_ff @(posedge clk) begin
        if (reset) begin
            regs    <= '0;
            written <= '0;
        end else if (write) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                if (wr_onehot_c[i]) begin
                    regs[i] <= data_in;
                end
            end
            written <= written | wr_onehot_c;
        end
    end

    rf_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NREGS  (NREGS),
        .BYPASS (BYPASS)
    ) u_port_a (
        .clk      (clk),
        .reset    (reset),
        .regs     (regs),
        .readnum  (readnum_a),
        .write    (write),
        .writenum (writenum),
        .data_in  (data_in),
        .data_out (data_out_a)
    );

    rf_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NREGS  (NREGS),
        .BYPASS (BYPASS)
    ) u_port_b (
        .clk      (clk),
        .reset    (reset),
        .regs     (regs),
        .readnum  (readnum_b),
        .write    (write),
        .writenum (writenum),
        .data_in  (data_in),
        .data_out (data_out_b)
    );

endmodule

// File: tb/tb_regfile_2r1w.sv
// Scoreboard bench: three configurations (16/3 bypass, 16/3 no bypass, 32/4 bypass) share stimulus.
module tb_regfile_2r1w;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        write;
    logic [31:0] data_in;
    logic [3:0]  writenum;
    logic [3:0]  readnum_a;
    logic [3:0]  readnum_b;

    logic [15:0] o0a, o0b, o1a, o1b;
    logic [7:0]  w0, w1;
    logic [31:0] o2a, o2b;
    logic [15:0] w2;

    regfile_2r1w #(.DATA_W(16), .ADDR_W(3), .NREGS(8), .BYPASS(1)) dut_byp (
        .clk(clk), .reset(reset), .data_in(data_in[15:0]), .writenum(writenum[2:0]),
        .write(write), .readnum_a(readnum_a[2:0]), .readnum_b(readnum_b[2:0]),
        .data_out_a(o0a), .data_out_b(o0b), .written(w0));

    regfile_2r1w #(.DATA_W(16), .ADDR_W(3), .NREGS(8), .BYPASS(0)) dut_nobyp (
        .clk(clk), .reset(reset), .data_in(data_in[15:0]), .writenum(writenum[2:0]),
        .write(write), .readnum_a(readnum_a[2:0]), .readnum_b(readnum_b[2:0]),
        .data_out_a(o1a), .data_out_b(o1b), .written(w1));

    regfile_2r1w #(.DATA_W(32), .ADDR_W(4), .NREGS(16), .BYPASS(1)) dut_wide (
        .clk(clk), .reset(reset), .data_in(data_in), .writenum(writenum),
        .write(write), .readnum_a(readnum_a), .readnum_b(readnum_b),
        .data_out_a(o2a), .data_out_b(o2b), .written(w2));

    typedef struct packed {
        logic [2:0][31:0] a;
        logic [2:0][31:0] b;
        logic [2:0][15:0] w;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: plain arrays per configuration.
    logic [31:0] mem [3][16];
    logic [15:0] wmap [3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic step(input logic rst, input logic wr, input logic [3:0] wn,
                        input logic [31:0] din, input logic [3:0] ra, input logic [3:0] rb);
        exp_t e;
        for (int d = 0; d < 3; d++) begin
            logic [3:0]  am;
            logic [31:0] dm;
            logic [3:0]  wn_d, ra_d, rb_d;
            logic [31:0] din_d;
            bit          byp;
            am    = (d == 2) ? 4'hF : 4'h7;
            dm    = (d == 2) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
            byp   = (d != 1);
            wn_d  = wn & am;
            ra_d  = ra & am;
            rb_d  = rb & am;
            din_d = din & dm;
            if (rst) begin
                e.a[d] = '0;
                e.b[d] = '0;
                for (int r = 0; r < 16; r++) mem[d][r] = '0;
                wmap[d] = '0;
            end else begin
                e.a[d] = (byp && wr && wn_d == ra_d) ? din_d : mem[d][ra_d];
                e.b[d] = (byp && wr && wn_d == rb_d) ? din_d : mem[d][rb_d];
                if (wr) begin
                    mem[d][wn_d]  = din_d;
                    wmap[d][wn_d] = 1'b1;
                end
            end
            e.w[d] = wmap[d];
        end
        reset     = rst;
        write     = wr;
        writenum  = wn;
        data_in   = din;
        readnum_a = ra;
        readnum_b = rb;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: outputs are presented once per edge for every queued cycle.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("byp_a",   {16'h0, o0a}, e.a[0]);
            chk("byp_b",   {16'h0, o0b}, e.b[0]);
            chk("byp_w",   {24'h0, w0},  {16'h0, e.w[0]});
            chk("nobyp_a", {16'h0, o1a}, e.a[1]);
            chk("nobyp_b", {16'h0, o1b}, e.b[1]);
            chk("nobyp_w", {24'h0, w1},  {16'h0, e.w[1]});
            chk("wide_a",  o2a,          e.a[2]);
            chk("wide_b",  o2b,          e.b[2]);
            chk("wide_w",  {16'h0, w2},  {16'h0, e.w[2]});
        end
    end

    initial begin
        reset = 1'b1; write = 1'b0; data_in = '0;
        writenum = '0; readnum_a = '0; readnum_b = '0;
        @(negedge clk);

        // Reset, then idle reads
        step(1'b1, 1'b0, 4'd0, 32'h0, 4'd0, 4'd7);
        step(1'b0, 1'b0, 4'd0, 32'h0, 4'd0, 4'd7);
        step(1'b0, 1'b0, 4'd0, 32'h0, 4'd0, 4'd7);
        chk("d1_a", {16'h0, o0a}, 32'h0);
        chk("d1_b", {16'h0, o0b}, 32'h0);
        chk("d1_w", {24'h0, w0},  32'h0);

        // Write then read
        step(1'b0, 1'b1, 4'd3, 32'h0000_BEEF, 4'd0, 4'd0);
        step(1'b0, 1'b0, 4'd0, 32'h0,         4'd3, 4'd3);
        chk("d2_a", {16'h0, o0a}, 32'h0000_BEEF);
        chk("d2_w", {24'h0, w0},  32'h08);

        // Collision: bypass vs no bypass
        step(1'b0, 1'b1, 4'd5, 32'h0000_AAAA, 4'd0, 4'd0);
        step(1'b0, 1'b1, 4'd5, 32'h0000_1234, 4'd5, 4'd5);
        chk("d3_byp_a",   {16'h0, o0a}, 32'h1234);
        chk("d3_byp_b",   {16'h0, o0b}, 32'h1234);
        chk("d3_nobyp_a", {16'h0, o1a}, 32'hAAAA);
        chk("d3_nobyp_b", {16'h0, o1b}, 32'hAAAA);
        step(1'b0, 1'b0, 4'd0, 32'h0, 4'd5, 4'd5);
        chk("d3_nobyp_next", {16'h0, o1a}, 32'h1234);

        // Fill all registers, read mirrored pairs
        for (int k = 0; k < 8; k++)
            step(1'b0, 1'b1, 4'(k), 32'h0101 * 32'(k), 4'd0, 4'd0);
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b0, 4'd0, 32'h0, 4'(k), 4'(7 - k));
            chk("d4_a", {16'h0, o0a}, 32'h0101 * 32'(k));
            chk("d4_b", {16'h0, o0b}, 32'h0101 * 32'(7 - k));
        end
        chk("d4_w", {24'h0, w0}, 32'hFF);

        // Reset beats a coincident write
        step(1'b1, 1'b1, 4'd2, 32'h0000_FFFF, 4'd0, 4'd0);
        step(1'b0, 1'b0, 4'd0, 32'h0,         4'd2, 4'd2);
        chk("d5_a", {16'h0, o0a}, 32'h0);
        chk("d5_w", {24'h0, w0},  32'h0);

        // Wide configuration, top register
        step(1'b0, 1'b1, 4'd15, 32'hDEAD_BEEF, 4'd0, 4'd0);
        step(1'b0, 1'b0, 4'd0,  32'h0,         4'd0, 4'd15);
        chk("d6_b", o2b, 32'hDEAD_BEEF);
        chk("d6_w", {16'h0, w2}, 32'h8000);

        // Randomised traffic with occasional mid-stream reset
        for (int n = 0; n < 500; n++) begin
            logic        r, w;
            logic [3:0]  wn, ra, rb;
            logic [31:0] d;
            r  = ($urandom_range(0, 49) == 0);
            w  = ($urandom_range(0, 9) < 6);
            wn = 4'($urandom_range(0, 15));
            ra = ($urandom_range(0, 3) == 0) ? wn : 4'($urandom_range(0, 15));
            rb = ($urandom_range(0, 3) == 0) ? ra : 4'($urandom_range(0, 15));
            d  = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            step(r, w, wn, d, ra, rb);
        end

        write = 1'b0;
        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
